// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with word-level generate/propagate
// outputs for cascading into a second-level lookahead unit.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             GG,
    output logic             GP
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64 || GROUP < 2 || GROUP > 8) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be 4..64 and a multiple of GROUP (2..8)");
    end

    // Handshake: a beat moves across an interface on a cycle where valid and
    // ready are both high at the rising edge; valid never waits on ready, and
    // IN_READY depends only on pipeline occupancy and OUT_READY.

    // ---------------- stage 1: bit, group and word generate/propagate
    logic [WIDTH-1:0]             w_g;
    logic [WIDTH-1:0]             w_p;
    logic [NG-1:0]                w_gk;
    logic [NG-1:0]                w_pk;
    logic                         w_gg;
    logic                         w_gp;
    logic [NG-1:0][GROUP-2:0]     w_gl;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Ripple form of the lookahead reduction: acc = g[j] | p[j] & acc.
    always_comb begin
        w_gk = '0;
        w_pk = '0;
        w_gl = '0;
        w_gg = 1'b0;
        w_gp = 1'b1;
        for (int k = 0; k < NG; k++) begin
            w_pk[k] = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                w_gk[k] = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & w_gk[k]);
                w_pk[k] = w_pk[k] & w_p[k*GROUP+j];
            end
            for (int j = 0; j < GROUP - 1; j++) begin
                w_gl[k][j] = w_g[k*GROUP+j];
            end
            w_gg = w_gk[k] | (w_pk[k] & w_gg);
            w_gp = w_gp & w_pk[k];
        end
    end

    // Stage 2 also needs the bit generates below each group's top bit to form
    // the intra-group carries; the top bit's generate is already folded into Gk.
    logic                         r_v1;
    logic [WIDTH-1:0]             r_p;
    logic [NG-1:0][GROUP-2:0]     r_gl;
    logic [NG-1:0]                r_gk;
    logic [NG-1:0]                r_pk;
    logic                         r_gg1;
    logic                         r_gp1;
    logic                         r_cin;

    logic r_v2;

    assign IN_READY = ~r_v1 | ~r_v2 | OUT_READY;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_v1  <= 1'b0;
            r_p   <= '0;
            r_gl  <= '0;
            r_gk  <= '0;
            r_pk  <= '0;
            r_gg1 <= 1'b0;
            r_gp1 <= 1'b0;
            r_cin <= 1'b0;
        end else begin
            if (IN_READY) begin
                r_v1 <= IN_VALID;
            end
            if (IN_READY && IN_VALID) begin
                r_p   <= w_p;
                r_gl  <= w_gl;
                r_gk  <= w_gk;
                r_pk  <= w_pk;
                r_gg1 <= w_gg;
                r_gp1 <= w_gp;
                r_cin <= CIN;
            end
        end
    end

    // ---------------- stage 2: group carries, intra-group carries, sum
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_s2_load;

    always_comb begin
        w_gc    = '0;
        w_c     = '0;
        w_gc[0] = r_cin;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = r_gk[k] | (r_pk[k] & w_gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            w_c[k*GROUP] = w_gc[k];
            for (int j = 1; j < GROUP; j++) begin
                w_c[k*GROUP+j] = r_gl[k][j-1] | (r_p[k*GROUP+j-1] & w_c[k*GROUP+j-1]);
            end
        end
    end

    assign w_sum     = r_p ^ w_c;
    assign w_cout    = w_gc[NG];
    assign w_ovf     = w_c[WIDTH-1] ^ w_gc[NG];
    assign w_s2_load = r_v1 & (~r_v2 | OUT_READY);

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_gg2;
    logic             r_gp2;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_v2   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_gg2  <= 1'b0;
            r_gp2  <= 1'b0;
        end else if (w_s2_load) begin
            r_v2   <= 1'b1;
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_gg2  <= r_gg1;
            r_gp2  <= r_gp1;
        end else if (OUT_READY) begin
            r_v2 <= 1'b0;
        end
    end

    assign OUT_VALID = r_v2;
    assign SUM       = r_sum;
    assign COUT      = r_cout;
    assign OVF       = r_ovf;
    assign GG        = r_gg2;
    assign GP        = r_gp2;

endmodule
